cplx_int_dump: RTL and testbench

Coherent complex integrate-and-dump stage that sits directly downstream of the complex multiplier in the TCAS DMSP chain. It averages N = 2^len_log2 valid complex products into one output sample. It also emits an alpha-max-beta-min magnitude estimate of that sample for the detector stage.

---
 rtl/dmsp_pkg.sv | 8 +
 rtl/cplx_mag_approx.sv | 55 +++++
 rtl/cplx_int_dump.sv | 112 +++++++++++
 tb/tb_cplx_int_dump.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmsp_pkg.sv
// Shared constants for the DMSP datapath stages.
package dmsp_pkg;

  localparam int unsigned DMSP_W         = 20;
  localparam int unsigned DMSP_LOG2N_MAX = 8;
  localparam int unsigned DMSP_ACC_W     = DMSP_W + DMSP_LOG2N_MAX;

endpackage

// File: rtl/cplx_mag_approx.sv
// Registered alpha-max-beta-min magnitude estimate of a complex sample.
module cplx_mag_approx
  import dmsp_pkg::*;
#(
  parameter int unsigned W = DMSP_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic         flush_i,
  input  logic [W-1:0] re_i,
  input  logic [W-1:0] im_i,
  output logic         valid_o,
  output logic [W-1:0] re_o,
  output logic [W-1:0] im_o,
  output logic [W-1:0] mag_o
);

  logic [W-1:0] abs_re, abs_im, max_ab, min_ab, mag_d;
  logic [W-1:0] re_q, im_q, mag_q;
  logic         valid_q;
  logic         load;

  always_comb begin
    // |-2^(W-1)| = 2^(W-1) still fits as W-bit unsigned.
    abs_re = re_i[W-1] ? (~re_i + W'(1)) : re_i;
    abs_im = im_i[W-1] ? (~im_i + W'(1)) : im_i;
    max_ab = (abs_re >= abs_im) ? abs_re : abs_im;
    min_ab = (abs_re >= abs_im) ? abs_im : abs_re;
    mag_d  = max_ab + (min_ab >> 1);
    load   = valid_i && !flush_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      mag_q   <= '0;
    end else begin
      valid_q <= load;
      if (load) begin
        re_q  <= re_i;
        im_q  <= im_i;
        mag_q <= mag_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign re_o    = re_q;
  assign im_o    = im_q;
  assign mag_o   = mag_q;

endmodule

// File: rtl/cplx_int_dump.sv
// Coherent complex integrate-and-dump: averages 2^len complex samples, then
// emits the average and its magnitude estimate.
module cplx_int_dump
  import dmsp_pkg::*;
#(
  parameter int unsigned W         = DMSP_W,
  parameter int unsigned LOG2N_MAX = DMSP_LOG2N_MAX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_i,
  input  logic [W-1:0] in_q,
  input  logic [3:0]   len_log2,
  input  logic         sync_clr,
  output logic         out_valid,
  output logic [W-1:0] out_i,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_mag
);

  localparam int unsigned AccW = W + LOG2N_MAX;
  localparam int unsigned CntW = LOG2N_MAX;

  logic signed [AccW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [AccW-1:0] sum_i, sum_q, shr_i, shr_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [3:0]             len_q, len_d, len_clamp, len_eff;
  logic [CntW:0]          last_cnt;
  logic                   dump;
  logic                   s1_valid_q, s1_valid_d;
  logic [W-1:0]           s1_i_q, s1_i_d, s1_q_q, s1_q_d;

  always_comb begin
    len_clamp = (len_log2 > 4'(LOG2N_MAX)) ? 4'(LOG2N_MAX) : len_log2;
    // A new window picks up the live length; an open window keeps its own.
    len_eff   = (cnt_q == '0) ? len_clamp : len_q;
    last_cnt  = ((CntW+1)'(1) << len_eff) - (CntW+1)'(1);
    dump      = in_valid && ({1'b0, cnt_q} == last_cnt);
    sum_i     = acc_i_q + {{LOG2N_MAX{in_i[W-1]}}, in_i};
    sum_q     = acc_q_q + {{LOG2N_MAX{in_q[W-1]}}, in_q};
    shr_i     = sum_i >>> len_eff;
    shr_q     = sum_q >>> len_eff;

    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    s1_valid_d = 1'b0;
    s1_i_d     = s1_i_q;
    s1_q_d     = s1_q_q;

    if (sync_clr) begin
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end else if (in_valid) begin
      if (cnt_q == '0) begin
        len_d = len_clamp;
      end
      if (dump) begin
        acc_i_d    = '0;
        acc_q_d    = '0;
        cnt_d      = '0;
        s1_i_d     = shr_i[W-1:0];
        s1_q_d     = shr_q[W-1:0];
        s1_valid_d = 1'b1;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
    end else begin
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      s1_valid_q <= s1_valid_d;
      s1_i_q     <= s1_i_d;
      s1_q_q     <= s1_q_d;
    end
  end

  // sync_clr also flushes a result already sitting in stage 1.
  cplx_mag_approx #(
    .W (W)
  ) u_mag (
    .clk_i   (clk),
    .rst_i   (reset),
    .valid_i (s1_valid_q),
    .flush_i (sync_clr),
    .re_i    (s1_i_q),
    .im_i    (s1_q_q),
    .valid_o (out_valid),
    .re_o    (out_i),
    .im_o    (out_q),
    .mag_o   (out_mag)
  );

endmodule

// File: tb/tb_cplx_int_dump.sv
// Directed self-checking bench for cplx_int_dump.
module tb_cplx_int_dump;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_i, in_q;
  logic [3:0]   len_log2;
  logic         sync_clr;
  logic         out_valid;
  logic [W-1:0] out_i, out_q, out_mag;

  int errors = 0;
  int checks = 0;
  int strobes = 0;

  cplx_int_dump #(
    .W         (20),
    .LOG2N_MAX (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_i      (in_i),
    .in_q      (in_q),
    .len_log2  (len_log2),
    .sync_clr  (sync_clr),
    .out_valid (out_valid),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_mag   (out_mag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) strobes++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int i, input int q);
    in_valid = 1'b1;
    in_i     = W'(i);
    in_q     = W'(q);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_i !== 20'd0) begin errors++;
      $display("FAIL reset_i got=%0d exp=0", $signed(out_i)); end
    checks++; if (out_q !== 20'd0) begin errors++;
      $display("FAIL reset_q got=%0d exp=0", $signed(out_q)); end
    checks++; if (out_mag !== 20'd0) begin errors++;
      $display("FAIL reset_mag got=%0d exp=0", out_mag); end
  endtask

  task automatic test_avg4();
    int base = strobes;
    len_log2 = 4'd2;
    repeat (4) send(100, -40);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL avg4_latency got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL avg4_valid got=%b exp=1", out_valid); end
    checks++; if (out_i !== 20'(100)) begin errors++;
      $display("FAIL avg4_i got=%0d exp=100", $signed(out_i)); end
    checks++; if (out_q !== 20'(-40)) begin errors++;
      $display("FAIL avg4_q got=%0d exp=-40", $signed(out_q)); end
    checks++; if (out_mag !== 20'(120)) begin errors++;
      $display("FAIL avg4_mag got=%0d exp=120", out_mag); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL avg4_strobe_len got=%b exp=0", out_valid); end
    idle(2);
    checks++; if (strobes - base !== 1) begin errors++;
      $display("FAIL avg4_count got=%0d exp=1", strobes - base); end
  endtask

  task automatic test_gaps();
    int base = strobes;
    len_log2 = 4'd2;
    send(-1, 0);
    send(0, 0);
    idle(1);
    send(0, 0);
    idle(3);
    send(0, 0);
    idle(3);
    checks++; if (out_i !== 20'hFFFFF) begin errors++;
      $display("FAIL gaps_i got=%0d exp=-1", $signed(out_i)); end
    checks++; if (out_q !== 20'd0) begin errors++;
      $display("FAIL gaps_q got=%0d exp=0", $signed(out_q)); end
    checks++; if (out_mag !== 20'd1) begin errors++;
      $display("FAIL gaps_mag got=%0d exp=1", out_mag); end
    checks++; if (strobes - base !== 1) begin errors++;
      $display("FAIL gaps_count got=%0d exp=1", strobes - base); end
  endtask

  task automatic test_ramp();
    int base = strobes;
    int e;
    len_log2 = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) send(k, -k);
      else tick();
      if (k >= 2) begin
        e = k - 1;
        checks++; if (out_valid !== 1'b1) begin errors++;
          $display("FAIL ramp_valid[%0d] got=%b exp=1", e, out_valid); end
        checks++; if (out_i !== 20'(e) || out_q !== 20'(-e)) begin errors++;
          $display("FAIL ramp_iq[%0d] got=%0d/%0d exp=%0d/%0d", e,
                   $signed(out_i), $signed(out_q), e, -e); end
        checks++; if (out_mag !== 20'(e + (e >> 1))) begin errors++;
          $display("FAIL ramp_mag[%0d] got=%0d exp=%0d", e, out_mag, e + (e >> 1)); end
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL ramp_end got=%b exp=0", out_valid); end
    idle(1);
    checks++; if (strobes - base !== 5) begin errors++;
      $display("FAIL ramp_count got=%0d exp=5", strobes - base); end
  endtask

  task automatic test_full();
    int base = strobes;
    len_log2 = 4'd8;
    repeat (256) send(-524288, -524288);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL full_valid got=%b exp=1", out_valid); end
    checks++; if (out_i !== 20'h80000 || out_q !== 20'h80000) begin errors++;
      $display("FAIL full_iq got=%0d/%0d exp=-524288", $signed(out_i), $signed(out_q)); end
    checks++; if (out_mag !== 20'd786432) begin errors++;
      $display("FAIL full_mag got=%0d exp=786432", out_mag); end
    idle(2);
    checks++; if (strobes - base !== 1) begin errors++;
      $display("FAIL full_count got=%0d exp=1", strobes - base); end
  endtask

  task automatic test_sync_clr();
    int base = strobes;
    len_log2 = 4'd3;
    repeat (5) send(50, 7);
    sync_clr = 1'b1;
    send(50, 7);
    sync_clr = 1'b0;
    repeat (8) send(8, 0);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL clr_valid got=%b exp=1", out_valid); end
    checks++; if (out_i !== 20'd8 || out_q !== 20'd0 || out_mag !== 20'd8) begin errors++;
      $display("FAIL clr_out got=%0d/%0d/%0d exp=8/0/8", $signed(out_i), $signed(out_q),
               out_mag); end
    idle(2);
    checks++; if (strobes - base !== 1) begin errors++;
      $display("FAIL clr_count got=%0d exp=1", strobes - base); end
    base = strobes;
    len_log2 = 4'd0;
    send(33, 0);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL clr_flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_i !== 20'd8) begin errors++;
      $display("FAIL clr_flush_hold got=%0d exp=8", $signed(out_i)); end
    idle(2);
    checks++; if (strobes - base !== 0) begin errors++;
      $display("FAIL clr_flush_count got=%0d exp=0", strobes - base); end
  endtask

  task automatic test_reset_mid();
    int base = strobes;
    len_log2 = 4'd2;
    send(9, 9);
    send(9, 9);
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_i !== 20'd0 || out_q !== 20'd0 ||
                  out_mag !== 20'd0) begin errors++;
      $display("FAIL rstmid_async got=%b/%0d/%0d/%0d exp=0/0/0/0", out_valid,
               $signed(out_i), $signed(out_q), out_mag); end
    idle(2);
    reset = 1'b0;
    repeat (3) send(4, -8);
    idle(2);
    checks++; if (strobes - base !== 0) begin errors++;
      $display("FAIL rstmid_discard got=%0d exp=0", strobes - base); end
    send(4, -8);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL rstmid_valid got=%b exp=1", out_valid); end
    checks++; if (out_i !== 20'd4 || out_q !== 20'(-8) || out_mag !== 20'd10) begin errors++;
      $display("FAIL rstmid_out got=%0d/%0d/%0d exp=4/-8/10", $signed(out_i),
               $signed(out_q), out_mag); end
    idle(2);
    base = strobes;
    len_log2 = 4'd0;
    send(33, 3);
    reset = 1'b1;
    #1;
    checks++; if (out_i !== 20'd0 || out_mag !== 20'd0) begin errors++;
      $display("FAIL rstdump_async got=%0d/%0d exp=0/0", $signed(out_i), out_mag); end
    tick();
    reset = 1'b0;
    idle(2);
    checks++; if (strobes - base !== 0 || out_i !== 20'd0) begin errors++;
      $display("FAIL rstdump_none got=%0d strobes out_i=%0d exp=0/0", strobes - base,
               $signed(out_i)); end
  endtask

  task automatic test_len_clamp();
    int base = strobes;
    len_log2 = 4'd12;
    repeat (255) send(3, -5);
    idle(2);
    checks++; if (strobes - base !== 0) begin errors++;
      $display("FAIL clamp_early got=%0d exp=0", strobes - base); end
    send(3, -5);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL clamp_valid got=%b exp=1", out_valid); end
    checks++; if (out_i !== 20'd3 || out_q !== 20'(-5) || out_mag !== 20'd6) begin errors++;
      $display("FAIL clamp_out got=%0d/%0d/%0d exp=3/-5/6", $signed(out_i),
               $signed(out_q), out_mag); end
    idle(1);
  endtask

  task automatic test_len_change();
    int base = strobes;
    len_log2 = 4'd2;
    send(10, 0);
    len_log2 = 4'd0;
    send(20, 0);
    send(30, 0);
    idle(2);
    checks++; if (strobes - base !== 0) begin errors++;
      $display("FAIL lenchg_early got=%0d exp=0", strobes - base); end
    send(40, 0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_i !== 20'd25 || out_mag !== 20'd25) begin
      errors++;
      $display("FAIL lenchg_out got=%b/%0d/%0d exp=1/25/25", out_valid, $signed(out_i),
               out_mag); end
    send(7, 1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_i !== 20'd7 || out_q !== 20'd1 ||
                  out_mag !== 20'd7) begin errors++;
      $display("FAIL lenchg_next got=%b/%0d/%0d/%0d exp=1/7/1/7", out_valid,
               $signed(out_i), $signed(out_q), out_mag); end
    idle(2);
    checks++; if (strobes - base !== 2) begin errors++;
      $display("FAIL lenchg_count got=%0d exp=2", strobes - base); end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_i     = '0;
    in_q     = '0;
    len_log2 = 4'd0;
    sync_clr = 1'b0;
    idle(3);
    test_reset();
    reset = 1'b0;
    idle(2);
    test_avg4();
    test_gaps();
    test_ramp();
    test_full();
    test_sync_clr();
    test_reset_mid();
    test_len_clamp();
    test_len_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
